dmem_responder: RTL and testbench

Responder end of the CPU core's data-memory load/store port. It accepts one request at a time from the core over a valid/ready handshake and services it from an internal word-organised RAM after a programmable number of wait states. It returns load data or a store acknowledgement over a second valid/ready handshake. It sits beside `top`, replacing the zero-latency data memory, so the core can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_ram_be.sv | 42 ++++
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//                Holds the FSM state enum, the data value returned by a
//                faulted access and the width of the wait-state counter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          DMEM_LAT_W    = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram_be
//  Description : Single-port word RAM with per-byte write enables.
//                Writes commit on the rising edge; the addressed word is
//                always visible combinationally on o_rdata. Contents are
//                not reset.
//  Ports       : clk      system clock
//                i_we     write strobe (qualified by i_be per byte lane)
//                i_addr   word index
//                i_wdata  write data
//                i_be     byte-lane enables, bit i covers bits [8i+7:8i]
//                o_rdata  word currently addressed
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_ram_be #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_be,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder side of the core's data-memory port. Accepts one
//                load/store at a time, waits LATENCY cycles, services it
//                from an internal byte-enable RAM and returns the result
//                over a valid/ready response channel.
//  Ports       : clk, nrst (async, active-high)
//                req_valid/req_ready, req_write, req_addr, req_wdata, req_be
//                resp_valid/resp_ready, resp_rdata, resp_err
//  Options     : DMEM_BOUNDS_CHECK_EN - when defined, a word index >= DEPTH
//                faults (resp_err=1, store suppressed, rdata DEAD_BEEF);
//                otherwise addresses wrap and resp_err is always 0.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int                    c_AW  = $clog2(DEPTH);
    localparam logic [DMEM_LAT_W-1:0] c_LAT = DMEM_LAT_W'(LATENCY);

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    logic [DMEM_LAT_W-1:0] r_cnt;

    logic                  r_write;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_write;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic [c_AW-1:0]       w_word;
    logic                  w_oob;
    logic                  w_ram_we;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused_addr;

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

    // With LATENCY = 0 the request enters RESP on its own accept edge,
    // before the latch holds it, so the live request fields are used then.
    assign w_write = w_accept ? req_write : r_write;
    assign w_addr  = w_accept ? req_addr  : r_addr;
    assign w_wdata = w_accept ? req_wdata : r_wdata;
    assign w_be    = w_accept ? req_be    : r_be;
    assign w_word  = w_addr[c_AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob         = |w_addr[31:c_AW+2];
    assign w_unused_addr = ^w_addr[1:0];
`else
    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign w_oob         = 1'b0;
    assign w_unused_addr = ^{w_addr[31:c_AW+2], w_addr[1:0]};
`endif

    // The store commits on the edge entering RESP, so a following load
    // (accepted only after the response handshake) sees the new data.
    assign w_ram_we = w_enter_resp && w_write && !w_oob;

    dmem_ram_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_word),
        .i_wdata (w_wdata),
        .i_be    (w_be),
        .o_rdata (w_ram_rdata)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == DMEM_LAT_W'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    // Wait-state counter
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_LAT;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - DMEM_LAT_W'(1);
        end
    end

    // Request latch
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response registers, loaded once on entry to RESP and held after
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err <= w_oob;
            if (w_oob) begin
                r_rdata <= DMEM_ERR_DATA;
            end else if (w_write) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Three instances
//                with LATENCY 2, 0 and 4 share clock and reset; a word-level
//                memory model per instance predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_ready [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    logic [31:0] mdl   [3][DEPTH];
    bit          known [3][DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (g == 0 ? 2 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk        (clk),
            .nrst       (nrst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a >> 2) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour of one access: word addressing, byte-lane merge,
    // optional bounds fault.
    function automatic void mdl_access(input int k, input bit w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] be,
                                       output logic [31:0] rd, output bit er);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        if (is_oob(a)) begin
            rd = 32'hDEAD_BEEF;
            er = 1'b1;
            return;
        end
        er = 1'b0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
            known[k][idx] = 1'b1;
            rd = 32'h0;
        end else begin
            rd = mdl[k][idx];
        end
    endfunction

    // Presents one request, waits for acceptance and then for resp_valid,
    // leaving the DUT in RESP. lat counts cycles from the accept edge.
    task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat);
        int n;
        req_valid[k]  = 1'b1;
        req_write[k]  = w;
        req_addr[k]   = a;
        req_wdata[k]  = d;
        req_be[k]     = be;
        resp_ready[k] = 1'b0;
        n = 0;
        while (!req_ready[k] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
        lat = 1;
        while (!resp_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic complete(input int k);
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (req_ready[k] !== 1'b1) begin
                bad++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", k, req_ready[k]);
            end
            total++;
            if (resp_valid[k] !== 1'b0) begin
                bad++; $display("FAIL reset_resp_valid[%0d] got=%b exp=0", k, resp_valid[k]);
            end
            total++;
            if (resp_rdata[k] !== 32'h0) begin
                bad++; $display("FAIL reset_resp_rdata[%0d] got=%h exp=0", k, resp_rdata[k]);
            end
            total++;
            if (resp_err[k] !== 1'b0) begin
                bad++; $display("FAIL reset_resp_err[%0d] got=%b exp=0", k, resp_err[k]);
            end
        end
        nrst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_lat2;
        int lat; logic [31:0] erd; bit eer;
        issue(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, lat);
        mdl_access(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, erd, eer);
        total++;
        if (lat != 3) begin bad++; $display("FAIL lat2_store_latency got=%0d exp=3", lat); end
        total++;
        if (resp_rdata[0] !== 32'h0) begin bad++; $display("FAIL lat2_store_rdata got=%h exp=0", resp_rdata[0]); end
        complete(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL lat2_load_latency got=%0d exp=3", lat); end
        total++;
        if (resp_rdata[0] !== 32'h1234_5678) begin
            bad++; $display("FAIL lat2_load_rdata got=%h exp=12345678", resp_rdata[0]);
        end
        complete(0);
    endtask

    task automatic test_byte_enable;
        int lat; logic [31:0] erd; bit eer;
        issue(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, lat);
        mdl_access(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, erd, eer);
        complete(0);
        issue(0, 1'b1, 32'h0, 32'h0000_00AA, 4'b0001, lat);
        mdl_access(0, 1'b1, 32'h0, 32'h0000_00AA, 4'b0001, erd, eer);
        complete(0);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, lat);
        total++;
        if (resp_rdata[0] !== 32'hFFFF_FFAA) begin
            bad++; $display("FAIL be_lane0 got=%h exp=ffffffaa", resp_rdata[0]);
        end
        complete(0);
        // Zero byte enables must leave the word untouched.
        issue(0, 1'b1, 32'h0, 32'h1122_3344, 4'b0000, lat);
        mdl_access(0, 1'b1, 32'h0, 32'h1122_3344, 4'b0000, erd, eer);
        complete(0);
        issue(0, 1'b0, 32'h3, 32'h0, 4'h0, lat);
        total++;
        if (resp_rdata[0] !== 32'hFFFF_FFAA) begin
            bad++; $display("FAIL be_zero got=%h exp=ffffffaa", resp_rdata[0]);
        end
        complete(0);
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] held; int errs;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        held = resp_rdata[0];
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== held || req_ready[0] !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL backpressure_hold unstable_cycles got=%0d exp=0 (rdata=%h held=%h)", errs, resp_rdata[0], held);
        end
        total++;
        if (held !== 32'h1234_5678) begin bad++; $display("FAIL backpressure_rdata got=%h exp=12345678", held); end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        total++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
            bad++; $display("FAIL backpressure_release got req_ready=%b resp_valid=%b exp 1/0", req_ready[0], resp_valid[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] erd; bit eer; int acc[3]; int n; int cyc;
        // LATENCY = 0 instance: store then load, two cycles each
        resp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h0;
        req_wdata[1] = 32'hCAFE_0001; req_be[1] = 4'hF;
        @(posedge clk); #1;
        mdl_access(1, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, erd, eer);
        total++;
        if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 || resp_rdata[1] !== 32'h0) begin
            bad++; $display("FAIL b2b_store_resp got valid=%b ready=%b rdata=%h exp 1/0/0", resp_valid[1], req_ready[1], resp_rdata[1]);
        end
        req_write[1] = 1'b0; req_wdata[1] = $urandom;
        @(posedge clk); #1;
        total++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", req_ready[1], resp_valid[1]);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        mdl_access(1, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        total++;
        if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== erd) begin
            bad++; $display("FAIL b2b_load got valid=%b rdata=%h exp 1/%h", resp_valid[1], resp_rdata[1], erd);
        end
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        // LATENCY = 2 instance: continuous loads, accepts every LATENCY+2 cycles
        resp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 40) begin
            if (req_ready[0]) begin acc[n] = cyc; n++; end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid[0] = 1'b0;
        total++;
        if (n != 3 || acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
            bad++; $display("FAIL b2b_throughput got accepts=%0d gaps=%0d,%0d exp 3 accepts gaps 4,4", n, acc[1]-acc[0], acc[2]-acc[1]);
        end
        cyc = 0;
        while (!(req_ready[0] && !resp_valid[0]) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        resp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        int lat; logic [31:0] erd; bit eer; bit seen;
        issue(2, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, lat);
        mdl_access(2, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, erd, eer);
        total++;
        if (lat != 5) begin bad++; $display("FAIL lat4_latency got=%0d exp=5", lat); end
        complete(2);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h8;
        req_wdata[2] = 32'h5555_5555; req_be[2] = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        #1;
        total++;
        if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0 || resp_rdata[2] !== 32'h0 || resp_err[2] !== 1'b0) begin
            bad++; $display("FAIL wait_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0",
                            req_ready[2], resp_valid[2], resp_rdata[2], resp_err[2]);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (resp_valid[2]) seen = 1'b1; end
        total++;
        if (seen) begin bad++; $display("FAIL wait_reset_dropped got resp_valid=1 exp=0"); end
        issue(2, 1'b0, 32'h8, 32'h0, 4'h0, lat);
        mdl_access(2, 1'b0, 32'h8, 32'h0, 4'h0, erd, eer);
        total++;
        if (resp_rdata[2] !== erd) begin bad++; $display("FAIL wait_reset_old_data got=%h exp=%h", resp_rdata[2], erd); end
        complete(2);
    endtask

    task automatic test_reset_in_resp;
        int lat; logic [31:0] erd; bit eer;
        issue(2, 1'b1, 32'hC, 32'h3333_3333, 4'hF, lat);
        mdl_access(2, 1'b1, 32'hC, 32'h3333_3333, 4'hF, erd, eer);
        nrst = 1'b1;
        #1;
        total++;
        if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
            bad++; $display("FAIL resp_reset_outputs got valid=%b ready=%b exp 0/1", resp_valid[2], req_ready[2]);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        issue(2, 1'b0, 32'hC, 32'h0, 4'h0, lat);
        mdl_access(2, 1'b0, 32'hC, 32'h0, 4'h0, erd, eer);
        total++;
        if (resp_rdata[2] !== 32'h3333_3333) begin
            bad++; $display("FAIL resp_reset_committed got=%h exp=33333333", resp_rdata[2]);
        end
        complete(2);
    endtask

    task automatic test_out_of_range;
        int lat; logic [31:0] erd; bit eer;
        logic [31:0] exp_ld; logic [31:0] exp_w0; logic exp_err;
`ifdef DMEM_BOUNDS_CHECK_EN
        exp_ld = 32'hDEAD_BEEF; exp_w0 = 32'h1357_2468; exp_err = 1'b1;
`else
        exp_ld = 32'h7777_7777; exp_w0 = 32'h7777_7777; exp_err = 1'b0;
`endif
        issue(0, 1'b1, 32'h0, 32'h1357_2468, 4'hF, lat);
        mdl_access(0, 1'b1, 32'h0, 32'h1357_2468, 4'hF, erd, eer);
        complete(0);
        issue(0, 1'b1, 32'h400, 32'h7777_7777, 4'hF, lat);
        mdl_access(0, 1'b1, 32'h400, 32'h7777_7777, 4'hF, erd, eer);
        total++;
        if (resp_err[0] !== exp_err || lat != 3) begin
            bad++; $display("FAIL oob_store got err=%b lat=%0d exp %b/3", resp_err[0], lat, exp_err);
        end
        complete(0);
        issue(0, 1'b0, 32'h400, 32'h0, 4'h0, lat);
        mdl_access(0, 1'b0, 32'h400, 32'h0, 4'h0, erd, eer);
        total++;
        if (resp_err[0] !== exp_err || resp_rdata[0] !== exp_ld) begin
            bad++; $display("FAIL oob_load got err=%b rdata=%h exp %b/%h", resp_err[0], resp_rdata[0], exp_err, exp_ld);
        end
        complete(0);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, lat);
        mdl_access(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        total++;
        if (resp_rdata[0] !== exp_w0 || resp_err[0] !== 1'b0) begin
            bad++; $display("FAIL oob_word0 got=%h err=%b exp=%h err=0", resp_rdata[0], resp_err[0], exp_w0);
        end
        complete(0);
    endtask

    task automatic test_random(input int k, input int n_txn);
        int lat; logic [31:0] erd; bit eer;
        logic [31:0] a; logic [31:0] d; logic [3:0] be; bit w; int word;
        for (int t = 0; t < n_txn; t++) begin
            word = $urandom_range(0, 31);
            a = (32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0) << 10)
                | (32'(word) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            w  = 1'($urandom);
            if (!w && !is_oob(a) && !known[k][word]) begin
                w = 1'b1; be = 4'hF;
            end
            issue(k, w, a, d, be, lat);
            mdl_access(k, w, a, d, be, erd, eer);
            total++;
            if (lat != lat_of(k) + 1 || resp_rdata[k] !== erd || resp_err[k] !== eer) begin
                bad++;
                $display("FAIL random[%0d] t=%0d w=%b a=%h got lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h err=%b",
                         k, t, w, a, lat, resp_rdata[k], resp_err[k], lat_of(k) + 1, erd, eer);
            end
            complete(k);
        end
    endtask

    initial begin
        nrst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   req_be[k] = '0;      resp_ready[k] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mdl[k][i] = '0; known[k][i] = 1'b0;
            end
        end
        test_reset();
        test_load_lat2();
        test_byte_enable();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_reset_in_resp();
        test_out_of_range();
        test_random(0, 40);
        test_random(1, 40);
        test_random(2, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
